int16_to_e4m3: RTL

Iterative converter from signed 16-bit two's-complement integers to the team's e4m3 float format. The format is sign, 4-bit exponent and 3-bit mantissa with an implicit leading 1, no denormals, no NaN/Inf, and zero encoded as 0x00. The block is the producer side of the e4m3 datapath: it turns integer operands into e4m3 words for the float adder. It uses a valid/ready handshake on both sides and a shift-one-bit-per-cycle normalization FSM.

---
 rtl/float_e4m3_pkg.sv | 19 +
 rtl/e4m3_round.sv | 36 +++
 rtl/int16_to_e4m3.sv | 92 +++++++++
 3 files changed

// File: rtl/float_e4m3_pkg.sv
// Shared e4m3 constants and converter FSM states, imported by the converter and the float adder.
// The optional round-to-nearest build is selected with E4M3_ROUND_NEAREST_EN (see e4m3_round).
package float_e4m3_pkg;

    localparam int E4M3_BIAS = 7;
    localparam int EXP_W     = 4;
    localparam int MAN_W     = 3;

    localparam logic [6:0] E4M3_MAX_MAG = 7'h7F;
    localparam logic [7:0] E4M3_ZERO    = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/e4m3_round.sv
// Combinational mantissa rounding, exponent carry and saturation for a normalized magnitude.
// E4M3_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module e4m3_round
    import float_e4m3_pkg::*;
(
    input  logic [14:0] mag,
    input  logic [5:0]  exponent,
    input  logic        sign,
    output logic [7:0]  y
);

    logic             round_up;
    logic [MAN_W:0]   man_sum;
    logic [5:0]       exp_final;

`ifdef E4M3_ROUND_NEAREST_EN
    assign round_up = mag[11] & ((|mag[10:0]) | mag[12]);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^mag[11:0];
    assign round_up        = 1'b0;
`endif

    // A mantissa carry-out leaves man_sum[2:0] at zero and bumps the exponent.
    assign man_sum   = {1'b0, mag[14:12]} + {{MAN_W{1'b0}}, round_up};
    assign exp_final = exponent + {5'd0, man_sum[MAN_W]};

    always_comb begin
        if (exp_final > 6'((1 << EXP_W) - 1)) begin
            y = {sign, E4M3_MAX_MAG};
        end else begin
            y = {sign, exp_final[EXP_W-1:0], man_sum[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/int16_to_e4m3.sv
// Iterative int16 -> e4m3 converter: one-bit-per-cycle normalization with valid/ready on both sides.
// Rounding mode is chosen inside e4m3_round via E4M3_ROUND_NEAREST_EN.
module int16_to_e4m3
    import float_e4m3_pkg::*;
#(
    parameter int BIAS = E4M3_BIAS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  y,
    output logic        is_output_valid,
    input  logic        out_ready
);

    conv_state_t state;
    conv_state_t state_next;
    logic        sign;
    logic [15:0] mag;
    logic [5:0]  exponent;
    logic [7:0]  y_round;

    e4m3_round u_round (
        .mag      (mag[14:0]),
        .exponent (exponent),
        .sign     (sign),
        .y        (y_round)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        in_ready        = 1'b0;
        is_output_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = NORM;
            end
            NORM: begin
                if (mag == 16'd0)  state_next = DONE;
                else if (mag[15])  state_next = ROUND;
            end
            ROUND: state_next = DONE;
            DONE: begin
                is_output_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Exponent starts as if the leading one were at bit 15 and drops by one per shift.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sign     <= 1'b0;
            mag      <= 16'd0;
            exponent <= 6'd0;
            y        <= E4M3_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign     <= in_data[15];
                        mag      <= in_data[15] ? (~in_data + 16'd1) : in_data;
                        exponent <= 6'(BIAS + 15);
                    end
                end
                NORM: begin
                    if (mag == 16'd0) begin
                        y <= E4M3_ZERO;
                    end else if (!mag[15]) begin
                        mag      <= mag << 1;
                        exponent <= exponent - 6'd1;
                    end
                end
                ROUND: y <= y_round;
                default: ;
            endcase
        end
    end

endmodule
